// File: rtl/calc_core_param_if.sv
// Keypad-to-display bus for calc_core_param.
// Carries the key strobe/code from the scanner and the display data back out.
//   keycode        5-bit key identifier, valid while newkey is high
//   newkey         level key strobe (edge-qualified inside the core)
//   Xdisplay       magnitude of X
//   LED_NEG_digit  X is negative
//   LED_OVW        sticky arithmetic overflow
//   busy           multiply in progress
interface calc_core_param_if #(
  parameter int unsigned NDIG = 4
);
  localparam int unsigned W = 4 * NDIG;

  logic [4:0]   keycode;
  logic         newkey;
  logic [W-1:0] Xdisplay;
  logic         LED_NEG_digit;
  logic         LED_OVW;
  logic         busy;

  // Driven by the keypad side, observes the display outputs.
  modport master (
    output keycode, newkey,
    input  Xdisplay, LED_NEG_digit, LED_OVW, busy
  );

  // The calculator core.
  modport slave (
    input  keycode, newkey,
    output Xdisplay, LED_NEG_digit, LED_OVW, busy
  );
endinterface

// File: rtl/calc_core_param.sv
// Parametrised hex keypad calculator core.
// Builds NDIG-digit hex operands from edge-qualified keycodes and performs chained
// add/sub (single cycle) and shift-add multiply (W cycles), plus negate, backspace
// and clear. X is held in W-bit two's complement; the display shows |X| and a sign.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  calc_core_param_if slave: keycode/newkey in; Xdisplay, LED_NEG_digit,
//        LED_OVW, busy out
module calc_core_param #(
  parameter int unsigned NDIG   = 4,
  parameter bit          MUL_EN = 1'b1
) (
  input logic               clk,
  input logic               rst,
  calc_core_param_if.slave  bus
);
  localparam int unsigned W  = 4 * NDIG;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {OpNone, OpAdd, OpSub, OpMul} op_e;

  logic [W-1:0]   x_q, x_d, y_q, y_d;
  op_e            op_q, op_d;
  logic           entry_q, entry_d;
  logic           ovw_q, ovw_d;
  logic           busy_q, busy_d;
  logic           newkey_q;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic           mneg_q, mneg_d;
  logic           mset_y_q, mset_y_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? (~v + W'(1)) : v;
  endfunction

  logic           accept;
  logic [W-1:0]   arith_res;
  logic           arith_ovf;
  logic [2*W-1:0] acc_nxt;
  logic [W-1:0]   mul_res;
  logic           mul_ovf;
  logic           mul_start;
  logic           mul_set_y;
  logic           do_clear;

  assign accept = bus.newkey & ~newkey_q;

  // Y op X for the single-cycle operators, with signed overflow detection.
  always_comb begin
    arith_res = y_q + x_q;
    arith_ovf = (y_q[W-1] == x_q[W-1]) && (arith_res[W-1] != y_q[W-1]);
    if (op_q == OpSub) begin
      arith_res = y_q - x_q;
      arith_ovf = (y_q[W-1] != x_q[W-1]) && (arith_res[W-1] != y_q[W-1]);
    end
  end

  // Multiply step and final result; only meaningful on the last busy cycle.
  always_comb begin
    acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_res = mneg_q ? (~acc_nxt[W-1:0] + W'(1)) : acc_nxt[W-1:0];
    // Magnitude limit is 2^(W-1)-1 when positive, 2^(W-1) when negative.
    mul_ovf = (acc_nxt[2*W-1:W] != '0) ||
              (acc_nxt[W-1] && (!mneg_q || (acc_nxt[W-2:0] != '0)));
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    op_d      = op_q;
    entry_d   = entry_q;
    ovw_d     = ovw_q;
    busy_d    = busy_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    mneg_d    = mneg_q;
    mset_y_d  = mset_y_q;
    cnt_d     = cnt_q;
    mul_start = 1'b0;
    mul_set_y = 1'b0;
    do_clear  = 1'b0;

    if (busy_q) begin
      if (accept && (bus.keycode == 5'h15)) begin
        do_clear = 1'b1;
      end else begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          busy_d = 1'b0;
          x_d    = mul_res;
          if (mset_y_q) y_d = mul_res;
          if (mul_ovf) ovw_d = 1'b1;
        end
      end
    end else if (accept) begin
      case (bus.keycode) inside
        [5'h00:5'h0F]: begin
          if (!entry_q) begin
            x_d     = {{(W-4){1'b0}}, bus.keycode[3:0]};
            entry_d = 1'b1;
          end else if (x_q[W-1:W-4] == 4'h0) begin
            x_d = {x_q[W-5:0], bus.keycode[3:0]};
          end
        end
        5'h10, 5'h11, 5'h12: begin
          if ((bus.keycode != 5'h12) || MUL_EN) begin
            if ((op_q != OpNone) && entry_q) begin
              if (op_q == OpMul) begin
                mul_start = 1'b1;
                mul_set_y = 1'b1;
              end else begin
                x_d = arith_res;
                y_d = arith_res;
                if (arith_ovf) ovw_d = 1'b1;
              end
            end else begin
              y_d = x_q;
            end
            unique case (bus.keycode[1:0])
              2'd0:    op_d = OpAdd;
              2'd1:    op_d = OpSub;
              default: op_d = OpMul;
            endcase
            entry_d = 1'b0;
          end
        end
        5'h13: begin
          if (op_q != OpNone) begin
            if (op_q == OpMul) begin
              mul_start = 1'b1;
            end else begin
              x_d = arith_res;
              if (arith_ovf) ovw_d = 1'b1;
            end
            op_d = OpNone;
          end
          entry_d = 1'b0;
        end
        5'h14: begin
          x_d     = '0;
          entry_d = 1'b0;
          ovw_d   = 1'b0;
        end
        5'h15: do_clear = 1'b1;
        5'h16: begin
          x_d     = ~x_q + W'(1);
          entry_d = 1'b0;
          if (x_q == {1'b1, {(W-1){1'b0}}}) ovw_d = 1'b1;
        end
        5'h17: begin
          if (entry_q) x_d = x_q >> 4;
        end
        default: ;
      endcase
    end

    // Latch operand magnitudes; the product commits W edges later.
    if (mul_start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{W{1'b0}}, mag(y_q)};
      mplier_d = mag(x_q);
      mneg_d   = x_q[W-1] ^ y_q[W-1];
      mset_y_d = mul_set_y;
    end

    if (do_clear) begin
      x_d      = '0;
      y_d      = '0;
      op_d     = OpNone;
      entry_d  = 1'b0;
      ovw_d    = 1'b0;
      busy_d   = 1'b0;
      mcand_d  = '0;
      acc_d    = '0;
      mplier_d = '0;
      mneg_d   = 1'b0;
      mset_y_d = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      op_q     <= OpNone;
      entry_q  <= 1'b0;
      ovw_q    <= 1'b0;
      busy_q   <= 1'b0;
      // A key held across reset must be released before it counts.
      newkey_q <= 1'b1;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      mneg_q   <= 1'b0;
      mset_y_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      op_q     <= op_d;
      entry_q  <= entry_d;
      ovw_q    <= ovw_d;
      busy_q   <= busy_d;
      newkey_q <= bus.newkey;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mneg_q   <= mneg_d;
      mset_y_q <= mset_y_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.Xdisplay      = mag(x_q);
  assign bus.LED_NEG_digit = x_q[W-1];
  assign bus.LED_OVW       = ovw_q;
  assign bus.busy          = busy_q;
endmodule

// File: tb/tb_calc_core_param.sv
// Directed testbench for calc_core_param (NDIG=4, MUL_EN=1).
module tb_calc_core_param;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  calc_core_param_if #(.NDIG(4)) bus ();

  calc_core_param #(
    .NDIG   (4),
    .MUL_EN (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clean strobe: accepted at the first edge, released before the second.
  task automatic press(input logic [4:0] k);
    @(negedge clk);
    bus.keycode = k;
    bus.newkey  = 1'b1;
    @(negedge clk);
    bus.newkey  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic check_out(input string tag, input logic [15:0] xd, input logic neg,
                           input logic ovw);
    check_eq({tag, "_x"},   {16'd0, bus.Xdisplay}, {16'd0, xd});
    check_eq({tag, "_neg"}, {31'd0, bus.LED_NEG_digit}, {31'd0, neg});
    check_eq({tag, "_ovw"}, {31'd0, bus.LED_OVW}, {31'd0, ovw});
  endtask

  initial begin
    int busy_cycles;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.keycode = 5'h00;
    bus.newkey  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_out("reset", 16'h0000, 1'b0, 1'b0);
    check_eq("reset_busy", {31'd0, bus.busy}, 32'd0);

    // Digit entry, fifth digit dropped.
    press(5'h01); press(5'h02); press(5'h03); press(5'h04); press(5'h05);
    check_out("digits", 16'h1234, 1'b0, 1'b0);

    // Add and chained add.
    press(5'h15);
    press(5'h0A); press(5'h10); press(5'h03); press(5'h13);
    check_out("add", 16'h000D, 1'b0, 1'b0);
    press(5'h10); press(5'h02); press(5'h10);
    check_out("chain_add", 16'h000F, 1'b0, 1'b0);

    // Subtract to negative, then negate.
    press(5'h15);
    press(5'h03); press(5'h11); press(5'h04); press(5'h13);
    check_out("sub_neg", 16'h0001, 1'b1, 1'b0);
    press(5'h16);
    check_out("negate", 16'h0001, 1'b0, 1'b0);

    // Signed add overflow, cleared by clear-entry.
    press(5'h15);
    press(5'h07); press(5'h0F); press(5'h0F); press(5'h0F);
    press(5'h10); press(5'h01); press(5'h13);
    check_out("add_ovf", 16'h8000, 1'b1, 1'b1);
    press(5'h14);
    check_out("clr_entry", 16'h0000, 1'b0, 1'b0);

    // Backspace.
    press(5'h15);
    press(5'h01); press(5'h02); press(5'h03); press(5'h17);
    check_out("backspace", 16'h0012, 1'b0, 1'b0);

    // Multiply: busy for exactly 16 cycles.
    press(5'h15);
    press(5'h01); press(5'h02); press(5'h12); press(5'h03);
    @(negedge clk);
    bus.keycode = 5'h13;
    bus.newkey  = 1'b1;
    @(posedge clk);
    #1;
    bus.newkey  = 1'b0;
    busy_cycles = 0;
    while (bus.busy && busy_cycles < 100) begin
      busy_cycles++;
      @(posedge clk);
      #1;
    end
    check_eq("mul_busy_cycles", busy_cycles, 32'd16);
    check_out("mul", 16'h0036, 1'b0, 1'b0);

    // Digit strobed while busy is dropped.
    press(5'h15);
    press(5'h01); press(5'h02); press(5'h12); press(5'h03); press(5'h13);
    check_eq("mul_busy_mid", {31'd0, bus.busy}, 32'd1);
    press(5'h09);
    wait_idle();
    check_out("mul_drop", 16'h0036, 1'b0, 1'b0);

    // Multiply overflow.
    press(5'h15);
    press(5'h01); press(5'h00); press(5'h00); press(5'h12);
    press(5'h01); press(5'h00); press(5'h00); press(5'h13);
    wait_idle();
    check_out("mul_ovf", 16'h0000, 1'b0, 1'b1);

    // Negative operand: -3 * 5 = -15.
    press(5'h15);
    press(5'h03); press(5'h16); press(5'h12); press(5'h05); press(5'h13);
    wait_idle();
    check_out("mul_neg", 16'h000F, 1'b1, 1'b0);

    // Chained multiply via add key updates Y: 2*3 then +4.
    press(5'h15);
    press(5'h02); press(5'h12); press(5'h03); press(5'h10);
    wait_idle();
    check_out("mul_chain", 16'h0006, 1'b0, 1'b0);
    press(5'h04); press(5'h13);
    check_out("mul_chain_add", 16'h000A, 1'b0, 1'b0);

    // Held strobe enters one digit.
    press(5'h15);
    @(negedge clk);
    bus.keycode = 5'h05;
    bus.newkey  = 1'b1;
    repeat (3) @(negedge clk);
    bus.newkey  = 1'b0;
    @(negedge clk);
    check_out("held_key", 16'h0005, 1'b0, 1'b0);

    // Strobe held through reset release is ignored.
    @(negedge clk);
    bus.keycode = 5'h07;
    bus.newkey  = 1'b1;
    rst         = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_out("held_rst", 16'h0000, 1'b0, 1'b0);
    bus.newkey = 1'b0;
    @(negedge clk);

    // All-clear during multiply aborts it and clears sticky overflow.
    press(5'h08); press(5'h00); press(5'h00); press(5'h00); press(5'h16);
    check_out("neg_min", 16'h8000, 1'b1, 1'b1);
    press(5'h03); press(5'h12); press(5'h05); press(5'h13);
    repeat (2) @(negedge clk);
    bus.keycode = 5'h15;
    bus.newkey  = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
    check_out("abort", 16'h0000, 1'b0, 1'b0);
    bus.newkey = 1'b0;
    repeat (20) @(negedge clk);
    check_out("abort_after", 16'h0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/calc_core_param.md
Name: calc_core_param

Overview:
Parametrised successor to the myCalc keypad calculator core. It accepts edge-qualified 5-bit keycodes and builds hexadecimal operands of NDIG digits. It supports chained add, subtract and multi-cycle multiply, plus negate, backspace and clear. It sits between the keypad scanner and the display driver, and presents sign-magnitude display data with a sticky overflow flag.

Parameters:
NDIG, 4, number of hex digits; datapath width W = 4*NDIG.
MUL_EN, 1, 1 = multiply key enabled; 0 = keycode 0x12 ignored.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-high reset
keycode  input  5  key identifier, valid while newkey high
newkey  input  1  key strobe, level, may stay high for many cycles
Xdisplay  output  W  magnitude of X (unsigned)
LED_NEG_digit  output  1  1 when X is negative
LED_OVW  output  1  sticky arithmetic overflow flag
busy  output  1  multiply in progress

Behaviour:
- Clock and reset: single clock domain clk. rst is asynchronous, active-high.
- Reset values:
  - X=0, Y=0, pending op=NONE, entry=0.
  - LED_OVW=0, busy=0, Xdisplay=0, LED_NEG_digit=0.
  - newkey_q=1, so a key held across reset is ignored until it is released.
- Key acceptance:
  - A key is accepted at a clk edge where newkey=1 and newkey_q=0.
  - Its effect is visible after that same edge.
  - While busy=1, only 0x15 is accepted; all other keys are dropped.
- Number representation: X is W-bit two's complement. Xdisplay=|X|. LED_NEG_digit=X[W-1]. Most-negative X displays 2^(W-1).
- Keycode map:
  - 0x00-0x0F digit:
    - entry=0: X<=digit, entry<=1.
    - entry=1 and X[W-1:W-4]!=0: ignored (digit field full).
    - otherwise X<={X[W-5:0],digit}.
  - 0x10 add, 0x11 sub, 0x12 mul:
    - If op!=NONE and entry=1: compute Y op X, X<=result, Y<=result.
    - Else Y<=X.
    - Then op<=key, entry<=0.
  - 0x13 equals: if op!=NONE, X<=Y op X, op<=NONE; always entry<=0.
  - 0x14 clear entry: X<=0, entry<=0, LED_OVW<=0.
  - 0x15 all clear: full reset state, except newkey_q. Accepted while busy and aborts the multiply; busy falls after that edge.
  - 0x16 negate: X<=-X (two's complement, wraps at most-negative and sets LED_OVW), entry<=0.
  - 0x17 backspace: if entry=1, X<=X>>4 (logical); else ignored.
  - 0x18-0x1F: ignored.
- Add/sub:
  - Single cycle, W-bit signed, result wraps.
  - Signed overflow sets LED_OVW.
- Multiply:
  - Shift-add on magnitudes, one bit per cycle.
  - busy rises at the accepting edge and stays high for exactly W cycles.
  - X, Y and busy update together at the W-th edge.
  - Sign = XOR of operand signs.
  - LED_OVW sets if the magnitude product exceeds 2^(W-1)-1 (positive) or 2^(W-1) (negative); stored result is the low W bits with sign applied.
- LED_OVW: sticky; cleared only by 0x14, 0x15 or rst. Arithmetic continues while it is set.
- newkey edge timing: a newkey rising during busy is consumed, not queued. newkey_q still tracks newkey every cycle.

Test Plan:
1. rst pulse, keys 1,2,3,4,5 each strobed once -> Xdisplay=0x1234 (fifth digit ignored), NEG=0, OVW=0.
2. Keys 0x0A,0x10,0x03,0x13 -> Xdisplay=0x000D. Then 0x10,0x02,0x10 -> chained result Xdisplay=0x000F.
3. Keys 0x03,0x11,0x04,0x13 -> Xdisplay=0x0001, NEG=1. Then 0x16 -> NEG=0, Xdisplay=0x0001.
4. Keys 7,F,F,F,0x10,1,0x13 -> Xdisplay=0x8000, NEG=1, OVW=1. Then 0x14 -> Xdisplay=0, OVW=0.
5. Keys 1,2,0x12,3,0x13 -> busy high exactly 16 cycles, then Xdisplay=0x0036. Digit strobed mid-busy is dropped. 0x100*0x100 -> OVW=1.
6. newkey held high for 3 cycles on key 5 -> single digit entered. newkey high through rst deassert -> no key taken. 0x15 during busy -> busy=0, all outputs zero next cycle.
